exec_mem_latch: RTL and testbench

//  Execute->Memory boundary of the Y86-64 pipeline, directly downstream of the ALU.

---
 rtl/exec_mem_latch_if.sv | 47 ++++
 rtl/exec_mem_latch.sv | 118 +++++++++++
 tb/tb_exec_mem_latch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_mem_latch_if.sv
// E->M boundary bundle: execute-stage inputs, CC/condition outputs and the M-stage register.
// The E side drives through the master modport; exec_mem_latch connects to the slave modport.
interface exec_mem_latch_if #(
  parameter int unsigned BIT_WID = 64,
  parameter int unsigned REG_WID = 4
);
  logic               e_valid;
  logic [3:0]         e_icode;
  logic [3:0]         e_ifun;
  logic [2:0]         e_stat;
  logic [BIT_WID-1:0] e_valE;
  logic [BIT_WID-1:0] e_valA;
  logic [REG_WID-1:0] e_dstE;
  logic [REG_WID-1:0] e_dstM;
  logic [3:0]         alu_cc;
  logic               e_set_cc;
  logic               m_exc;
  logic               m_stall;
  logic               m_bubble;

  logic [3:0]         cc_q;
  logic               e_cnd;

  logic               M_valid;
  logic [3:0]         M_icode;
  logic [3:0]         M_ifun;
  logic [2:0]         M_stat;
  logic               M_cnd;
  logic [BIT_WID-1:0] M_valE;
  logic [BIT_WID-1:0] M_valA;
  logic [REG_WID-1:0] M_dstE;
  logic [REG_WID-1:0] M_dstM;

  modport master (
    output e_valid, e_icode, e_ifun, e_stat, e_valE, e_valA, e_dstE, e_dstM,
    output alu_cc, e_set_cc, m_exc, m_stall, m_bubble,
    input  cc_q, e_cnd,
    input  M_valid, M_icode, M_ifun, M_stat, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  e_valid, e_icode, e_ifun, e_stat, e_valE, e_valA, e_dstE, e_dstM,
    input  alu_cc, e_set_cc, m_exc, m_stall, m_bubble,
    output cc_q, e_cnd,
    output M_valid, M_icode, M_ifun, M_stat, M_cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/exec_mem_latch.sv
// Y86-64 Execute->Memory boundary: CC register, jXX/cmovXX condition evaluation, M pipeline reg.
// Optional macro COND_UNSIGNED_EN adds unsigned conditions b (ifun 7) and ae (ifun 8).
module exec_mem_latch #(
  parameter int unsigned BIT_WID = 64,
  parameter int unsigned REG_WID = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_mem_latch_if.slave bus
);

  localparam logic [3:0]         IcodeNop  = 4'h1;
  localparam logic [3:0]         IcodeCmov = 4'h2;
  localparam logic [3:0]         IcodeJxx  = 4'h7;
  localparam logic [2:0]         StatBub   = 3'd0;
  localparam logic [2:0]         StatIns   = 3'd4;
  localparam logic [REG_WID-1:0] RNone     = '1;
  localparam logic [3:0]         CcReset   = 4'b0001;

  typedef struct packed {
    logic               valid;
    logic [3:0]         icode;
    logic [3:0]         ifun;
    logic [2:0]         stat;
    logic               cnd;
    logic [BIT_WID-1:0] val_e;
    logic [BIT_WID-1:0] val_a;
    logic [REG_WID-1:0] dst_e;
    logic [REG_WID-1:0] dst_m;
  } m_reg_t;

  localparam m_reg_t MRegReset = '{
    valid: 1'b0, icode: IcodeNop, ifun: 4'h0, stat: StatBub, cnd: 1'b0,
    val_e: '0, val_a: '0, dst_e: RNone, dst_m: RNone
  };

  logic [3:0] cc_reg_q, cc_reg_d;
  m_reg_t     m_q, m_d, m_load;
  logic       zf, sf, of, sf_xor_of;
  logic       cond_raw, cond_legal, is_cond_instr, ins_fault, cc_we;

  // Conditions read the registered CC only; the ALU flags never bypass into e_cnd.
  always_comb begin
    zf         = cc_reg_q[0];
    sf         = cc_reg_q[1];
    of         = cc_reg_q[2];
    sf_xor_of  = sf ^ of;
    cond_raw   = 1'b0;
    cond_legal = 1'b1;
    case (bus.e_ifun)
      4'h0:    cond_raw = 1'b1;
      4'h1:    cond_raw = sf_xor_of | zf;
      4'h2:    cond_raw = sf_xor_of;
      4'h3:    cond_raw = zf;
      4'h4:    cond_raw = ~zf;
      4'h5:    cond_raw = ~sf_xor_of;
      4'h6:    cond_raw = ~sf_xor_of & ~zf;
`ifdef COND_UNSIGNED_EN
      4'h7:    cond_raw = cc_reg_q[3];
      4'h8:    cond_raw = ~cc_reg_q[3];
`endif
      default: cond_legal = 1'b0;
    endcase
    is_cond_instr = (bus.e_icode == IcodeCmov) || (bus.e_icode == IcodeJxx);
    ins_fault     = is_cond_instr & ~cond_legal;
  end

  always_comb begin
    cc_we    = bus.e_valid & bus.e_set_cc & ~bus.m_exc & ~bus.m_stall & ~bus.m_bubble &
               ~ins_fault;
    cc_reg_d = cc_we ? bus.alu_cc : cc_reg_q;
  end

  always_comb begin
    m_load.valid = 1'b1;
    m_load.icode = bus.e_icode;
    m_load.ifun  = bus.e_ifun;
    m_load.stat  = ins_fault ? StatIns : bus.e_stat;
    m_load.cnd   = cond_raw;
    m_load.val_e = bus.e_valE;
    m_load.val_a = bus.e_valA;
    // A cmov whose condition fails keeps flowing but must not write its destination.
    m_load.dst_e = ((bus.e_icode == IcodeCmov) && !cond_raw) ? RNone : bus.e_dstE;
    m_load.dst_m = bus.e_dstM;

    m_d = m_load;
    if (bus.m_bubble) begin
      m_d = MRegReset;
    end else if (bus.m_stall) begin
      m_d = m_q;
    end else if (!bus.e_valid) begin
      m_d = MRegReset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_reg_q <= CcReset;
      m_q      <= MRegReset;
    end else begin
      cc_reg_q <= cc_reg_d;
      m_q      <= m_d;
    end
  end

  assign bus.cc_q    = cc_reg_q;
  assign bus.e_cnd   = cond_raw;
  assign bus.M_valid = m_q.valid;
  assign bus.M_icode = m_q.icode;
  assign bus.M_ifun  = m_q.ifun;
  assign bus.M_stat  = m_q.stat;
  assign bus.M_cnd   = m_q.cnd;
  assign bus.M_valE  = m_q.val_e;
  assign bus.M_valA  = m_q.val_a;
  assign bus.M_dstE  = m_q.dst_e;
  assign bus.M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_exec_mem_latch.sv
// Directed vector bench for exec_mem_latch: table of single-cycle vectors plus hand sequences
// for stall/bubble holding and asynchronous reset during a stall.
module tb_exec_mem_latch;

`ifdef COND_UNSIGNED_EN
  localparam bit UnsEn = 1'b1;
`else
  localparam bit UnsEn = 1'b0;
`endif

  logic clk;
  logic rst_n;

  exec_mem_latch_if #(.BIT_WID(64), .REG_WID(4)) bus ();

  exec_mem_latch #(.BIT_WID(64), .REG_WID(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [2:0]  stat;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  alu_cc;
    logic        set_cc;
    logic        exc;
    logic        stall;
    logic        bubble;
    logic        x_cnd;
    logic [3:0]  x_cc;
    logic        x_valid;
    logic [3:0]  x_icode;
    logic [2:0]  x_stat;
    logic        x_mcnd;
    logic [63:0] x_val_e;
    logic [3:0]  x_dst_e;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.e_valid  = v.valid;
    bus.e_icode  = v.icode;
    bus.e_ifun   = v.ifun;
    bus.e_stat   = v.stat;
    bus.e_valE   = v.val_e;
    bus.e_valA   = v.val_a;
    bus.e_dstE   = v.dst_e;
    bus.e_dstM   = v.dst_m;
    bus.alu_cc   = v.alu_cc;
    bus.e_set_cc = v.set_cc;
    bus.m_exc    = v.exc;
    bus.m_stall  = v.stall;
    bus.m_bubble = v.bubble;
  endtask

  task automatic drive_simple(input logic [63:0] val_e, input logic set_cc, input logic [3:0] cc,
                              input logic stall, input logic bubble);
    bus.e_valid  = 1'b1;
    bus.e_icode  = 4'h6;
    bus.e_ifun   = 4'h0;
    bus.e_stat   = 3'd1;
    bus.e_valE   = val_e;
    bus.e_valA   = 64'h0;
    bus.e_dstE   = 4'h2;
    bus.e_dstM   = 4'hF;
    bus.alu_cc   = cc;
    bus.e_set_cc = set_cc;
    bus.m_exc    = 1'b0;
    bus.m_stall  = stall;
    bus.m_bubble = bubble;
  endtask

  initial begin
    //          vld icode  ifun   stat  valE      valA      dstE   dstM   alu_cc   set exc stl bub
    //          x_cnd x_cc  x_vld x_icode x_stat x_mcnd x_valE x_dstE
    vecs[0]  = '{1'b1, 4'h6, 4'h0, 3'd1, 64'h10, 64'h20, 4'h2, 4'h8, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'b0010, 1'b1, 4'h6, 3'd1, 1'b1, 64'h10, 4'h2};
    vecs[1]  = '{1'b1, 4'h7, 4'h1, 3'd1, 64'h0, 64'h100, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'b0010, 1'b1, 4'h7, 3'd1, 1'b1, 64'h0, 4'hF};
    vecs[2]  = '{1'b1, 4'h7, 4'h3, 3'd1, 64'h0, 64'h104, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'b0010, 1'b1, 4'h7, 3'd1, 1'b0, 64'h0, 4'hF};
    vecs[3]  = '{1'b1, 4'h6, 4'h1, 3'd1, 64'h5, 64'h0, 4'h3, 4'hF, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b1, 4'b0010, 1'b1, 4'h6, 3'd1, 1'b1, 64'h5, 4'h3};
    vecs[4]  = '{1'b1, 4'h6, 4'h4, 3'd1, 64'h99, 64'h0, 4'h4, 4'hF, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b1, 4'b0010, 1'b1, 4'h6, 3'd1, 1'b1, 64'h5, 4'h3};
    vecs[5]  = '{1'b1, 4'h6, 4'h0, 3'd1, 64'h0, 64'h0, 4'h5, 4'hF, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'b0001, 1'b1, 4'h6, 3'd1, 1'b1, 64'h0, 4'h5};
    vecs[6]  = '{1'b1, 4'h2, 4'h4, 3'd1, 64'hABCD, 64'hABCD, 4'h3, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 4'b0001, 1'b1, 4'h2, 3'd1, 1'b0, 64'hABCD, 4'hF};
    vecs[7]  = '{1'b1, 4'h2, 4'h3, 3'd2, 64'h77, 64'h77, 4'h3, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'b0001, 1'b1, 4'h2, 3'd2, 1'b1, 64'h77, 4'h3};
    vecs[8]  = '{1'b1, 4'h7, 4'h9, 3'd1, 64'h0, 64'h200, 4'hF, 4'hF, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'b0001, 1'b1, 4'h7, 3'd4, 1'b0, 64'h0, 4'hF};
    vecs[9]  = '{1'b1, 4'h2, 4'hF, 3'd1, 64'h66, 64'h66, 4'h6, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'b0001, 1'b1, 4'h2, 3'd4, 1'b0, 64'h66, 4'hF};
    vecs[10] = '{1'b1, 4'h6, 4'h0, 3'd1, 64'h55, 64'h0, 4'h2, 4'hF, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1,
                 1'b1, 4'b0001, 1'b0, 4'h1, 3'd0, 1'b0, 64'h0, 4'hF};
    vecs[11] = '{1'b0, 4'h6, 4'h5, 3'd1, 64'h55, 64'h0, 4'h2, 4'hF, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'b0001, 1'b0, 4'h1, 3'd0, 1'b0, 64'h0, 4'hF};
    vecs[12] = '{1'b1, 4'h6, 4'h6, 3'd1, 64'h42, 64'h0, 4'h7, 4'hF, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'b0110, 1'b1, 4'h6, 3'd1, 1'b0, 64'h42, 4'h7};
    vecs[13] = '{1'b1, 4'h7, 4'h6, 3'd1, 64'h0, 64'h300, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 4'b0110, 1'b1, 4'h7, 3'd1, 1'b1, 64'h0, 4'hF};
    vecs[14] = '{1'b1, 4'h6, 4'h2, 3'd1, 64'h3, 64'h0, 4'h8, 4'hF, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'b1000, 1'b1, 4'h6, 3'd1, 1'b0, 64'h3, 4'h8};
    vecs[15] = '{1'b1, 4'h7, 4'h7, 3'd1, 64'h0, 64'h400, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 UnsEn, 4'b1000, 1'b1, 4'h7, (UnsEn ? 3'd1 : 3'd4), UnsEn, 64'h0, 4'hF};
    vecs[16] = '{1'b1, 4'h7, 4'h8, 3'd1, 64'h0, 64'h404, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 4'b1000, 1'b1, 4'h7, (UnsEn ? 3'd1 : 3'd4), 1'b0, 64'h0, 4'hF};

    rst_n = 1'b0;
    drive_simple(64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    bus.e_valid = 1'b0;
    #12;
    chk("reset_cc", 64'(bus.cc_q), 64'h1);
    chk("reset_M_valid", 64'(bus.M_valid), 64'h0);
    chk("reset_M_icode", 64'(bus.M_icode), 64'h1);
    chk("reset_M_stat", 64'(bus.M_stat), 64'h0);
    chk("reset_M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("reset_M_dstM", 64'(bus.M_dstM), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_e_cnd", i), 64'(bus.e_cnd), 64'(vecs[i].x_cnd));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cc", i), 64'(bus.cc_q), 64'(vecs[i].x_cc));
      chk($sformatf("v%0d_M_valid", i), 64'(bus.M_valid), 64'(vecs[i].x_valid));
      chk($sformatf("v%0d_M_icode", i), 64'(bus.M_icode), 64'(vecs[i].x_icode));
      chk($sformatf("v%0d_M_stat", i), 64'(bus.M_stat), 64'(vecs[i].x_stat));
      chk($sformatf("v%0d_M_cnd", i), 64'(bus.M_cnd), 64'(vecs[i].x_mcnd));
      chk($sformatf("v%0d_M_valE", i), bus.M_valE, vecs[i].x_val_e);
      chk($sformatf("v%0d_M_dstE", i), 64'(bus.M_dstE), 64'(vecs[i].x_dst_e));
      if (vecs[i].x_valid && !vecs[i].stall) begin
        chk($sformatf("v%0d_M_ifun", i), 64'(bus.M_ifun), 64'(vecs[i].ifun));
        chk($sformatf("v%0d_M_valA", i), bus.M_valA, vecs[i].val_a);
        chk($sformatf("v%0d_M_dstM", i), 64'(bus.M_dstM), 64'(vecs[i].dst_m));
      end
    end

    // Stall holds M for three cycles, then bubble overrides a simultaneous stall.
    @(negedge clk);
    drive_simple(64'h1234, 1'b0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("stall_load_valE", bus.M_valE, 64'h1234);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_simple(64'hDEAD, 1'b0, 4'h0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_valE", c), bus.M_valE, 64'h1234);
      chk($sformatf("stall%0d_valid", c), 64'(bus.M_valid), 64'h1);
    end
    @(negedge clk);
    drive_simple(64'hDEAD, 1'b0, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("stall_bubble_valid", 64'(bus.M_valid), 64'h0);
    chk("stall_bubble_icode", 64'(bus.M_icode), 64'h1);
    chk("stall_bubble_valE", bus.M_valE, 64'h0);

    // Asynchronous reset asserted mid-cycle while the M register is stalled.
    @(negedge clk);
    drive_simple(64'h5A, 1'b1, 4'b0100, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_cc", 64'(bus.cc_q), 64'h4);
    chk("pre_rst_valE", bus.M_valE, 64'h5A);
    @(negedge clk);
    drive_simple(64'h77, 1'b0, 4'h0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cc", 64'(bus.cc_q), 64'h1);
    chk("async_rst_valid", 64'(bus.M_valid), 64'h0);
    chk("async_rst_dstE", 64'(bus.M_dstE), 64'hF);
    chk("async_rst_valE", bus.M_valE, 64'h0);
    @(posedge clk);
    #1;
    chk("rst_held_valid", 64'(bus.M_valid), 64'h0);
    chk("rst_held_cc", 64'(bus.cc_q), 64'h1);
    @(negedge clk);
    bus.m_stall = 1'b0;
    bus.e_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(bus.M_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
